// File: rtl/alu_seq.sv
// alu_seq: runs a 16-bit add/shift/xor as two passes through an external
// 8-bit combinational ALU. The FSM goes IDLE -> FIRST -> SECOND -> FIN.
// All outputs, including the ALU drive signals, are registered.
module alu_seq #(
    parameter logic [3:0] OPC_ADD = 4'b0000,
    parameter logic [3:0] OPC_LSH = 4'b0001,
    parameter logic [3:0] OPC_RSH = 4'b0010,
    parameter logic [3:0] OPC_XOR = 4'b0011,
    parameter logic [3:0] OPC_NOP = 4'b1111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  opsel,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero16,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_funct,
    output logic        alu_sc_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_sc_out,
    input  logic        alu_zero
);

    localparam logic [1:0] SEL_RSH = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, FIN} state_t;

    state_t      state_reg;
    logic [1:0]  op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [7:0]  first_byte_reg;   // ALU result of the first pass, held until completion
    logic        zero_first_reg;   // ALU zero flag of the first pass

    // Map the operation select onto the ALU {OP,funct} code.
    function automatic logic [3:0] opc(input logic [1:0] sel);
        case (sel)
            2'b00:   opc = OPC_ADD;
            2'b01:   opc = OPC_LSH;
            2'b10:   opc = OPC_RSH;
            default: opc = OPC_XOR;
        endcase
    endfunction

    // Sequencer: latches the request, steers bytes through the ALU and
    // commits the 16-bit result only on the transition into FIN.
    // alu_sc_in doubles as the internal carry between the two passes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg           <= IDLE;
            op_reg              <= '0;
            a_reg               <= '0;
            b_reg               <= '0;
            first_byte_reg      <= '0;
            zero_first_reg      <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            result              <= '0;
            cout                <= 1'b0;
            zero16              <= 1'b0;
            alu_a               <= '0;
            alu_b               <= '0;
            {alu_op, alu_funct} <= OPC_NOP;
            alu_sc_in           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg              <= opsel;
                        a_reg               <= a16;
                        b_reg               <= b16;
                        busy                <= 1'b1;
                        state_reg           <= FIRST;
                        {alu_op, alu_funct} <= opc(opsel);
                        // Right shift walks from the high byte down so the
                        // shifted-out bit feeds the lower byte.
                        alu_a     <= (opsel == SEL_RSH) ? a16[15:8] : a16[7:0];
                        alu_b     <= (opsel == SEL_RSH) ? b16[15:8] : b16[7:0];
                        alu_sc_in <= (opsel == SEL_XOR) ? 1'b0 : cin;
                    end
                end
                FIRST: begin
                    first_byte_reg <= alu_out;
                    zero_first_reg <= alu_zero;
                    alu_a     <= (op_reg == SEL_RSH) ? a_reg[7:0] : a_reg[15:8];
                    alu_b     <= (op_reg == SEL_RSH) ? b_reg[7:0] : b_reg[15:8];
                    alu_sc_in <= (op_reg == SEL_XOR) ? 1'b0 : alu_sc_out;
                    state_reg <= SECOND;
                end
                SECOND: begin
                    result <= (op_reg == SEL_RSH) ? {first_byte_reg, alu_out}
                                                  : {alu_out, first_byte_reg};
                    cout                <= (op_reg == SEL_XOR) ? 1'b0 : alu_sc_out;
                    zero16              <= zero_first_reg & alu_zero;
                    done                <= 1'b1;
                    alu_a               <= '0;
                    alu_b               <= '0;
                    {alu_op, alu_funct} <= OPC_NOP;
                    alu_sc_in           <= 1'b0;
                    state_reg           <= FIN;
                end
                FIN: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: models the external 8-bit ALU, runs a vector table,
// random operations against a 16-bit arithmetic reference, and hand-written
// sequences for ignored STARTs and mid-operation reset.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  opsel;
    logic [15:0] a16, b16;
    logic        cin;
    logic        busy, done, cout, zero16;
    logic [15:0] result;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [1:0]  alu_op, alu_funct;
    logic        alu_sc_in, alu_sc_out, alu_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opsel(opsel),
        .a16(a16), .b16(b16), .cin(cin), .busy(busy), .done(done),
        .result(result), .cout(cout), .zero16(zero16),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_funct(alu_funct),
        .alu_sc_in(alu_sc_in), .alu_out(alu_out), .alu_sc_out(alu_sc_out),
        .alu_zero(alu_zero)
    );

    // External 8-bit ALU
    always_comb begin
        logic [8:0] sum;
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_sc_in};
        alu_out    = 8'h00;
        alu_sc_out = 1'b0;
        case ({alu_op, alu_funct})
            4'b0000: begin alu_out = sum[7:0]; alu_sc_out = sum[8]; end
            4'b0001: begin alu_out = {alu_a[6:0], alu_sc_in}; alu_sc_out = alu_a[7]; end
            4'b0010: begin alu_out = {alu_sc_in, alu_a[7:1]}; alu_sc_out = alu_a[0]; end
            4'b0011: begin alu_out = alu_a ^ alu_b; alu_sc_out = 1'b0; end
            default: begin alu_out = 8'h00; alu_sc_out = 1'b0; end
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    // 16-bit reference: returns {cout, zero16, result}
    function automatic logic [17:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic c);
        logic [16:0] w;
        logic        co;
        case (op)
            2'b00:   begin w = {1'b0, a} + {1'b0, b} + {16'b0, c}; co = w[16]; end
            2'b01:   begin w = {a, c}; co = w[16]; end
            2'b10:   begin w = {1'b0, c, a[15:1]}; co = a[0]; end
            default: begin w = {1'b0, a ^ b}; co = 1'b0; end
        endcase
        return {co, (w[15:0] == 16'h0000), w[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for DONE (bounded), report latency and
    // ALU drive seen in FIRST/SECOND; also checks FIN and return to IDLE.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic c, output int lat, output logic sc1, output logic sc2,
                          output logic [7:0] a1, output logic [3:0] opc1);
        @(negedge clk);
        start = 1'b1; opsel = op; a16 = a; b16 = b; cin = c;
        @(posedge clk); #1;
        lat  = 1;
        sc1  = alu_sc_in;
        a1   = alu_a;
        opc1 = {alu_op, alu_funct};
        sc2  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'($urandom); opsel = 2'($urandom);
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) sc2 = alu_sc_in;
        end
        chk("fin_busy", busy, 1);
        chk("fin_nop", {alu_op, alu_funct, alu_sc_in}, {4'hF, 1'b0});
    endtask

    task automatic after_fin();
        logic [15:0] r;
        r = result;
        @(posedge clk); #1;
        chk("idle_busy_done", {busy, done}, 2'b00);
        chk("result_hold", result, r);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b;
        logic        c;
        logic [15:0] res;
        logic        co, z;
    } vec_t;

    initial begin
        vec_t        vecs[9];
        int          lat;
        logic        sc1, sc2;
        logic [7:0]  a1;
        logic [3:0]  opc1;
        logic [17:0] exp;

        vecs[0] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{2'b01, 16'h8081, 16'h0000, 1'b1, 16'h0103, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 16'h0181, 16'h0000, 1'b0, 16'h00C0, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 16'h5AA5, 16'h5AA5, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFF00, 1'b0, 1'b0};
        vecs[7] = '{2'b10, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{2'b00, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        reset_n = 1'b0; start = 1'b0; opsel = 2'b00; a16 = '0; b16 = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, result, cout, zero16}, 20'h0);
        chk("reset_alu", {alu_op, alu_funct, alu_a, alu_b, alu_sc_in}, {4'hF, 17'h0});
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, lat, sc1, sc2, a1, opc1);
            $display("vec %0d op=%0d a=%h b=%h cin=%0d -> res=%h cout=%0d zero=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, result, cout, zero16, lat);
            chk("vec_latency", lat, 3);
            chk("vec_result", {result, cout, zero16}, {vecs[i].res, vecs[i].co, vecs[i].z});
            chk("vec_first_byte", a1, (vecs[i].op == 2'b10) ? vecs[i].a[15:8] : vecs[i].a[7:0]);
            chk("vec_opcode", opc1, {2'b00, vecs[i].op});
            if (vecs[i].op == 2'b11) chk("xor_sc_in", {sc1, sc2}, 2'b00);
            else                      chk("first_sc_in", sc1, vecs[i].c);
            if (i == 1) chk("add_carry_second", sc2, 1'b1);
            after_fin();
        end

        // Random operations against the 16-bit reference
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [15:0] a, b;
            logic        c;
            op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            exp = ref_model(op, a, b, c);
            run_op(op, a, b, c, lat, sc1, sc2, a1, opc1);
            $display("rnd %0d op=%0d a=%h b=%h cin=%0d -> res=%h cout=%0d zero=%0d", k, op, a, b,
                     c, result, cout, zero16);
            chk("rnd_latency", lat, 3);
            chk("rnd_result", {cout, zero16, result}, exp);
            @(posedge clk); #1;
        end

        // START held through FIRST/SECOND/FIN with changing operands
        @(negedge clk);
        start = 1'b1; opsel = 2'b00; a16 = 16'h00FF; b16 = 16'h0001; cin = 1'b0;
        @(posedge clk); #1;
        chk("hold_accept", busy, 1);
        @(negedge clk); opsel = 2'b11; a16 = 16'hFFFF; b16 = 16'h1234; cin = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); opsel = 2'b01; a16 = 16'h7777;
        @(posedge clk); #1;
        chk("hold_done", done, 1);
        chk("hold_result", {result, cout, zero16}, {16'h0100, 2'b00});
        @(negedge clk); opsel = 2'b00; a16 = 16'h0001; b16 = 16'h0001; cin = 1'b0;
        @(posedge clk); #1;
        chk("hold_fin_ignored", {busy, done}, 2'b00);
        @(posedge clk); #1;
        chk("next_accept", busy, 1);
        @(negedge clk); start = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin @(posedge clk); #1; lat++; end
        $display("seq hold -> res=%h lat=%0d", result, lat);
        chk("next_latency", lat, 3);
        chk("next_result", result, 16'h0002);
        @(posedge clk); #1;

        // Reset asserted during SECOND
        @(negedge clk);
        start = 1'b1; opsel = 2'b00; a16 = 16'h1111; b16 = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, result, cout, zero16}, 20'h0);
        chk("abort_alu", {alu_op, alu_funct, alu_a, alu_b, alu_sc_in}, {4'hF, 17'h0});
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        @(negedge clk); reset_n = 1'b1;
        run_op(2'b00, 16'h0001, 16'h0001, 1'b0, lat, sc1, sc2, a1, opc1);
        $display("post-reset add -> res=%h lat=%0d", result, lat);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_result", {result, cout, zero16}, {16'h0002, 2'b00});
        after_fin();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter OPC_ADD, default 4'b0000, SHALL be the {OP,funct} code driven for the add-with-carry operation.
REQ-002 Parameter OPC_LSH, default 4'b0001, SHALL be the {OP,funct} code driven for the shift-left operation.
REQ-003 Parameter OPC_RSH, default 4'b0010, SHALL be the {OP,funct} code driven for the shift-right operation.
REQ-004 Parameter OPC_XOR, default 4'b0011, SHALL be the {OP,funct} code driven for the exclusive-OR operation.
REQ-005 Parameter OPC_NOP, default 4'b1111, SHALL be the {OP,funct} code driven whenever no operation is in flight.
REQ-006 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 RESET_N  in  1  SHALL be the reset, asynchronous and active-low.
REQ-008 START  in  1  SHALL request a 16-bit operation; it is sampled only in IDLE.
REQ-009 OPSEL  in  2  SHALL select the operation: 00 ADD, 01 LSH, 10 RSH, 11 XOR.
REQ-010 A16, B16  in  16 each  SHALL be the operands; CIN  in  1  SHALL be the carry-in or shift-in bit.
REQ-011 BUSY  out  1  SHALL be high in every state except IDLE.
REQ-012 DONE  out  1  SHALL be a one-cycle completion pulse.
REQ-013 RESULT  out  16, COUT  out  1, ZERO16  out  1  SHALL be the registered result, the final carry or shift-out bit, and the all-zero flag.
REQ-014 ALU_A, ALU_B  out  8, ALU_OP  out  2, ALU_FUNCT  out  2, ALU_SC_IN  out  1  SHALL drive the 8-bit ALU.
REQ-015 ALU_OUT  in  8, ALU_SC_OUT  in  1, ALU_ZERO  in  1  SHALL return the combinational ALU result.

Function
REQ-016 The FSM SHALL have four states: IDLE, FIRST, SECOND and FIN.
REQ-017 In IDLE with START=1, the block SHALL latch OPSEL, A16, B16 and CIN and move to FIRST; the sequence is then FIRST->SECOND->FIN->IDLE unconditionally.
REQ-018 For ADD and LSH, the FIRST state SHALL process the low byte and SECOND the high byte; for RSH, FIRST SHALL process the high byte and SECOND the low byte.
REQ-019 For XOR, the FIRST state SHALL process the low byte and SECOND the high byte.
REQ-020 In FIRST, ALU_SC_IN SHALL equal the latched CIN for ADD/LSH/RSH and 0 for XOR.
REQ-021 In SECOND, ALU_SC_IN SHALL equal the ALU_SC_OUT registered at the end of FIRST, or 0 for XOR.
REQ-022 In FIRST and SECOND, {ALU_OP,ALU_FUNCT} SHALL equal the OPC_* code of the latched op; ALU_A and ALU_B SHALL be the selected bytes of A and B.
REQ-023 In IDLE and FIN, {ALU_OP,ALU_FUNCT} SHALL be OPC_NOP, ALU_A and ALU_B SHALL be 0, and ALU_SC_IN SHALL be 0.
REQ-024 At the end of each of FIRST and SECOND, ALU_OUT SHALL be captured into the corresponding RESULT byte and ALU_SC_OUT into the internal carry.
REQ-025 ZERO16 SHALL be the AND of ALU_ZERO sampled in FIRST and in SECOND.
REQ-026 COUT SHALL be the ALU_SC_OUT captured in SECOND; it SHALL be forced to 0 for XOR.
REQ-027 RESULT, COUT and ZERO16 SHALL update only at completion (the transition into FIN) and SHALL hold until the next completion.
REQ-028 DONE SHALL be 1 exactly in FIN; latency from the START-accept edge to DONE is 3 cycles.
REQ-029 START while BUSY=1, including during FIN, SHALL be ignored with no queuing; latched operands SHALL be unaffected by input changes after acceptance.
REQ-030 A new START SHALL be accepted in the IDLE cycle immediately after FIN, giving a peak throughput of one operation per 4 cycles.

Reset
REQ-031 While RESET_N=0, the block SHALL force IDLE immediately, asynchronously to CLK.
REQ-032 While RESET_N=0, BUSY=0, DONE=0, RESULT=16'h0000, COUT=0, ZERO16=0 and the internal carry = 0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no DONE pulse, and the partial result SHALL be discarded.
REQ-034 The first START SHALL be accepted on the first rising edge after RESET_N deasserts.

Verification
REQ-035 ADD A=0x00FF B=0x0001 CIN=0 -> DONE 3 cycles after accept, RESULT=0x0100, COUT=0, ZERO16=0.
REQ-036 ADD A=0xFFFF B=0x0001 CIN=0 -> RESULT=0x0000, COUT=1, ZERO16=1; the ALU sees SC_IN=1 in SECOND.
REQ-037 LSH A=0x8081 CIN=1 -> RESULT=0x0103, COUT=1; RSH A=0x0181 CIN=0 -> RESULT=0x00C0, COUT=1, with the high byte processed first.
REQ-038 XOR A=0x5AA5 B=0x5AA5 CIN=1 -> RESULT=0x0000, ZERO16=1, COUT=0, and ALU_SC_IN stays 0 throughout.
REQ-039 START pulsed in FIRST, SECOND and FIN with changed operands -> ignored; the original result completes, and a new START one cycle after DONE is accepted.
REQ-040 RESET_N low during SECOND -> immediate IDLE with all outputs 0 and no DONE; a following ADD 0x0001+0x0001 -> RESULT=0x0002.
